// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one word fetch at a time on a
// valid/ready imem port and holds the returned word for decode.
// Ports: clk, rst_n (async low) | imem_req_valid/ready/addr,
// imem_rsp_valid/data | redirect_valid/pc | id_valid/ready/instr/pc.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  fetch_state_t state;
  if_id_t       out_q;
  logic [31:0]  pc;
  logic [31:0]  inflight_pc;

  logic        slot_free;
  logic        req_fire;
  logic        rsp_done;
  logic        fill;
  logic        consume;
  logic [31:0] redirect_tgt;
  logic        redirect_lsb_unused;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // A request may only go out when the output register is empty
  // or being drained this very cycle, so a response always lands.
  assign slot_free = !out_q.valid || id_ready;

  assign imem_req_valid = rst_n
                        && (state == S_REQ)
                        && slot_free
                        && !redirect_valid;
  assign imem_req_addr  = pc;

  assign req_fire = imem_req_valid && imem_req_ready;

  // Response that closes the outstanding fetch, redirect excluded.
  assign rsp_done = !redirect_valid
                  && (state != S_REQ)
                  && imem_rsp_valid;

  assign fill    = rsp_done && (state == S_WAIT);
  assign consume = out_q.valid && id_ready;

  assign id_valid = out_q.valid;
  assign id_instr = out_q.instr;
  assign id_pc    = out_q.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      unique case (1'b1)
        redirect_valid: begin
          pc <= redirect_tgt;
          // An outstanding fetch must still be swallowed.
          if ((state != S_REQ) && !imem_rsp_valid)
            state <= S_DROP;
          else
            state <= S_REQ;
        end
        req_fire: begin
          inflight_pc <= pc;
          pc          <= pc + 32'd4;
          state       <= S_WAIT;
        end
        rsp_done: begin
          state <= S_REQ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (redirect_valid) begin
      out_q.valid <= 1'b0;
    end else if (fill) begin
      out_q.valid <= 1'b1;
      out_q.instr <= imem_rsp_data;
      out_q.pc    <= inflight_pc;
    end else if (consume) begin
      out_q.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a
// latency-randomised memory and a fetch-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          n_cons = 0;
  int          seen_bad = 0;
  logic [31:0] bad_pc = 32'h0000_0001;

  // memory + stream model
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          mem_epoch = 0;
  int          epoch = 0;
  logic [31:0] fetch_pc = RST_PC;
  int          kmin = 1;
  int          kmax = 1;
  int          cyc = 0;
  logic [31:0] acc_log[$];
  int          acc_cyc[$];

  bit          s_acc;
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_id_valid;
  logic [31:0] s_id_pc;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mem_busy = 1'b0;
    mem_cnt  = 0;
    epoch++;
    fetch_pc = RST_PC;
  endtask

  // One clock cycle of stimulus plus the memory/stream model.
  task automatic step(input bit rdy, input bit redir,
                      input logic [31:0] tgt, input bit mrdy);
    bit acc;
    @(negedge clk);
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = mrdy;
    imem_rsp_valid = mem_busy && (mem_cnt == 1);
    imem_rsp_data  = $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    acc   = imem_req_valid && imem_req_ready;
    s_acc = acc;
    if (redir)
      chk("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
    #2;
    if (acc) begin
      if (mem_busy) miss("single_outstanding");
      chk("req_addr", imem_req_addr, fetch_pc);
      acc_log.push_back(imem_req_addr);
      acc_cyc.push_back(cyc);
      fetch_pc = fetch_pc + 32'd4;
    end
    if (imem_rsp_valid) begin
      if (!redir && mem_epoch == epoch)
        exp_q.push_back('{pc: mem_addr, ins: imem_rsp_data});
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      fetch_pc = {tgt[31:2], 2'b00};
    end
    if (acc) begin
      mem_busy  = 1'b1;
      mem_cnt   = int'($urandom_range(kmax, kmin));
      mem_addr  = imem_req_addr;
      mem_epoch = epoch;
    end
    cyc++;
  endtask

  task automatic run_until_acc(input string name, input bit rdy);
    int n;
    n = 0;
    do begin
      step(rdy, 1'b0, 32'd0, 1'b1);
      n++;
    end while (!s_acc && n < 20);
    if (!s_acc) miss(name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mem_busy || exp_q.size() != 0 || id_valid) && n < 30) begin
      step(1'b1, 1'b0, 32'd0, 1'b0);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_idle", {31'd0, mem_busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RST_PC);
  endtask

  // Monitor: pops the scoreboard on every consumed instruction.
  initial begin
    logic        pv, pr, pd, prst;
    logic [31:0] ppc, pins;
    item_t       it;
    pv = 0; pr = 0; pd = 0; prst = 0; ppc = 0; pins = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && prst && pv && !pr && !pd) begin
        chk("hold_valid", {31'd0, id_valid}, 32'd1);
        chk("hold_pc", id_pc, ppc);
        chk("hold_instr", id_instr, pins);
      end
      if (rst_n && id_valid) begin
        if (id_pc == bad_pc) seen_bad++;
        if (id_ready) begin
          if (exp_q.size() == 0) begin
            miss("no_unexpected_output");
          end else begin
            it = exp_q.pop_front();
            chk("id_pc", id_pc, it.pc);
            chk("id_instr", id_instr, it.ins);
            n_cons++;
          end
        end
      end
      pv = id_valid; pr = id_ready; pd = redirect_valid;
      prst = rst_n; ppc = id_pc; pins = id_instr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit r, d, m;
    kmin = 1; kmax = 1;
    do_reset();

    // sequential fetch, k=1, full throughput
    cyc = 0;
    acc_log.delete();
    acc_cyc.delete();
    n0 = n_cons;
    repeat (8) step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t1_accepts", acc_log.size(), 32'd4);
    if (acc_log.size() >= 3) begin
      chk("t1_addr0", acc_log[0], 32'h1000);
      chk("t1_addr1", acc_log[1], 32'h1004);
      chk("t1_addr2", acc_log[2], 32'h1008);
      chk("t1_gap01", acc_cyc[1] - acc_cyc[0], 32'd2);
      chk("t1_gap12", acc_cyc[2] - acc_cyc[1], 32'd2);
    end
    chk("t1_consumed", n_cons - n0, 32'd3);

    // backpressure
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("bp_id_valid", {31'd0, s_id_valid}, 32'd1);
      chk("bp_no_req", {31'd0, s_req_valid}, 32'd0);
      chk("bp_id_pc", s_id_pc, 32'h100C);
    end
    kmin = 2; kmax = 2;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("bp_release_req", {31'd0, s_req_valid}, 32'd1);
    chk("bp_release_addr", s_req_addr, 32'h1010);

    // redirect while waiting
    bad_pc = 32'h1010;
    seen_bad = 0;
    step(1'b1, 1'b1, 32'h0000_2002, 1'b1);
    kmin = 1; kmax = 1;
    run_until_acc("t3_req_timeout", 1'b1);
    chk("t3_target", s_req_addr, 32'h2000);
    chk("t3_gap", acc_cyc[$] - acc_cyc[$-1], 32'd3);

    // redirect coincident with response
    step(1'b1, 1'b1, 32'h0000_3100, 1'b1);
    chk("t3_dropped_shown", seen_bad, 32'd0);
    bad_pc = 32'h2000;
    seen_bad = 0;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t4_req_valid", {31'd0, s_req_valid}, 32'd1);
    chk("t4_req_addr", s_req_addr, 32'h3100);
    chk("t4_flushed", {31'd0, s_id_valid}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t4_held", {31'd0, s_id_valid}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_3800, 1'b1);
    kmin = 4; kmax = 4;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t4_flush_valid", {31'd0, s_id_valid}, 32'd0);
    chk("t4_flush_req", s_req_addr, 32'h3800);
    chk("t4_dropped_shown", seen_bad, 32'd0);

    // double redirect while dropping
    bad_pc = 32'h3800;
    seen_bad = 0;
    step(1'b1, 1'b1, 32'h0000_3000, 1'b1);
    step(1'b1, 1'b1, 32'h0000_4000, 1'b1);
    kmin = 1; kmax = 1;
    run_until_acc("t5_req_timeout", 1'b1);
    chk("t5_target", s_req_addr, 32'h4000);
    chk("t5_gap", acc_cyc[$] - acc_cyc[$-1], 32'd5);
    drain();
    chk("t5_dropped_shown", seen_bad, 32'd0);

    // wrap
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run_until_acc("t6_top_timeout", 1'b1);
    chk("t6_top", s_req_addr, 32'hFFFF_FFFC);
    run_until_acc("t6_wrap_timeout", 1'b1);
    chk("t6_wrap", s_req_addr, 32'h0000_0000);
    drain();

    // async reset while waiting
    step(1'b1, 1'b1, 32'h0000_5000, 1'b1);
    run_until_acc("t7_req_timeout", 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    kmin = 3; kmax = 3;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t7_wait_accept", s_req_addr, 32'h5004);
    @(posedge clk);
    #2;
    chk("t7_pre_rst_pc", id_pc, 32'h5000);
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    model_reset();
    #1;
    chk("async_id_pc", id_pc, 32'd0);
    chk("async_id_instr", id_instr, 32'd0);
    chk("async_id_valid", {31'd0, id_valid}, 32'd0);
    chk("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("restart_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("restart_addr", imem_req_addr, RST_PC);
    run_until_acc("restart_timeout", 1'b1);
    chk("restart_accept", s_req_addr, RST_PC);

    // randomized traffic
    kmin = 1; kmax = 3;
    n0 = n_cons;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(99, 0) < 70);
      d = ($urandom_range(99, 0) < 3);
      m = ($urandom_range(99, 0) < 60);
      step(r, d, $urandom, m);
    end
    drain();
    chk("rand_progress", {31'd0, (n_cons - n0) > 150}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
